fmap_stream_tx: RTL and testbench
=================================

# fmap_stream_tx

Feature-map stream transmitter. It sits on the output side of the convolution layer: it captures the flat result bus in one cycle and streams the map out one pixel per beat over a valid/ready interface, in raster order. This lets downstream stages (pooling, activation, host readout) consume conv results serially instead of through a wide parallel bus. Pixel packing and ordering match the conv layer's `res` bus exactly.

## Interface
- `DATA_WIDTH`, 16: bits per pixel; the raw value is passed through, half-float or SInt.
- `H`, 28: feature-map height (conv output, 32-5+1).
- `W`, 28: feature-map width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `fmap` in `H*W*DATA_WIDTH`: flat feature map. Pixel (r,c) occupies bits `[((H-1-r)*W + (W-1-c))*DATA_WIDTH +: DATA_WIDTH]`, so top-left is at the MSB end.
- `fmap_valid` in 1: `fmap` holds a complete map.
- `fmap_ready` out 1: block is idle and will capture.
- `m_data` out `DATA_WIDTH`: current pixel.
- `m_valid` out 1: `m_data` and the sideband signals are valid.
- `m_ready` in 1: downstream accepts the beat.
- `m_row` out `$clog2(H)`: row of the current pixel.
- `m_col` out `$clog2(W)`: column of the current pixel.
- `m_eol` out 1: current pixel is the last of its row (`m_col == W-1`).
- `m_last` out 1: current pixel is the last of the frame, (H-1,W-1).

## Operation
- FSM with two states:
  - IDLE: `fmap_ready=1`, `m_valid=0`.
  - SEND: `fmap_ready=0`, `m_valid=1`.
- Capture:
  - In IDLE, `fmap_valid=1` at an edge latches `fmap` into the internal buffer.
  - On the same edge: `m_row=0`, `m_col=0`, and the state moves to SEND.
- Beat: a beat transfers on any edge where `m_valid && m_ready`.
  - `m_col` increments.
  - At `W-1`, `m_col` wraps to 0 and `m_row` increments.
  - `m_data` advances to the next pixel. Recommended implementation: the buffer shifts left by `DATA_WIDTH` and `m_data` is its top slice.
- End of frame:
  - A beat with `m_last=1` returns the FSM to IDLE; `m_valid` falls on that edge.
  - Counters clear to 0; buffer contents become don't-care.
- Backpressure: while `m_valid && !m_ready`, all of the following are held stable: `m_data`, `m_row`, `m_col`, `m_eol`, `m_last`.
- `fmap_valid` in SEND is ignored; `fmap` may change freely after capture.
- `m_eol` and `m_last` are decoded combinationally from the counters.
- No arithmetic on data; pixel bits are passed through unmodified.
- `H=1` or `W=1` is legal: `m_eol` is always 1 when `W=1`.

## Timing
- Reset values: state IDLE, `fmap_ready=1`, `m_valid=0`, `m_data=0`, `m_row=0`, `m_col=0`.
- `m_eol` and `m_last` are 0 while `m_valid=0`.
- Capture at edge k puts the first beat valid in cycle k+1 (latency 1).
- Throughput is 1 pixel/cycle with `m_ready` held high. A frame occupies `H*W` consecutive cycles, e.g. 784 at defaults.
- The last beat at edge j gives `fmap_ready=1` in cycle j+1. The earliest next capture is edge j+1, with its first beat in cycle j+2: one bubble between frames.
- Reset asserted mid-frame: `m_valid` drops immediately (asynchronously) and the frame is abandoned. After release the block is in IDLE and awaits a fresh `fmap_valid`; there is no partial resume.
- `fmap_ready` is a function of state only and does not depend on `fmap_valid`.

## Structure
- Shared header: state localparams (`ST_IDLE`, `ST_SEND`) and a pixel-index helper `pix_idx(r,c,W,H)`. The conv testbenches reuse the helper to pack and check maps.
- No sub-module: the FSM, counters and shift buffer fit in one module.

## Test plan
- Basic frame at defaults, with `fmap` pixel (0,0)=16'h3c00, (0,1)=16'h4000, (27,27)=16'hc000 and all others = `r*W+c` -> in order, beat 0 = 3c00, beat 1 = 4000, beat 783 = c000 with `m_last=1`. `m_eol` is high on beats 27, 55, …, 783. All 784 beats arrive in consecutive cycles.
- Backpressure: drop `m_ready` for 3 cycles at beat 100 -> data 16'd100 and row/col (3,16) stay stable. No beat is lost or duplicated, and the total is still 784.
- Random `m_ready` (50 %) over 2 back-to-back frames with distinct maps -> the scoreboard matches both frames exactly. `fmap_ready` rises exactly 1 cycle after each `m_last` beat.
- `fmap_valid` pulsed with a different map at beat 200 -> ignored; the stream continues with the original map.
- Reset asserted at beat 400 -> `m_valid=0` and `fmap_ready=1` immediately. A new frame after release starts at (0,0) with the new map's pixel 0.
- Small config with `H=2`, `W=3`, `fmap` = 96'h0001_0002_0003_0004_0005_0006 -> beats 0001, 0002, 0003 (`m_eol`), 0004, 0005, 0006 (`m_eol`, `m_last`).

Source files
------------

// File: rtl/fmap_stream_tx_pkg.sv
// Shared definitions for the feature-map stream transmitter and the conv benches
// that pack or check flat maps.
package fmap_stream_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Pixel slot of (r,c) in a flat map; top-left sits at the MSB end.
    function automatic int unsigned pix_idx(int unsigned r, int unsigned c,
                                            int unsigned w, int unsigned h);
        return (h - 1 - r) * w + (w - 1 - c);
    endfunction

    // Counter width that stays at least 1 bit for single-row/column maps.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Pixel stream (valid/ready plus raster sideband) leaving the transmitter.
interface fmap_stream_tx_if
    import fmap_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 28,
    parameter int W          = 28
);
    localparam int RW = cnt_width(H);
    localparam int CW = cnt_width(W);

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [RW-1:0]         m_row;
    logic [CW-1:0]         m_col;
    logic                  m_eol;
    logic                  m_last;

    modport master (
        output m_data, m_valid, m_row, m_col, m_eol, m_last,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_row, m_col, m_eol, m_last,
        output m_ready
    );
endinterface

// File: rtl/fmap_stream_tx.sv
// Captures a flat conv result map in one cycle and streams it out one pixel per
// beat in raster order; the buffer shifts left so the current pixel is its top slice.
module fmap_stream_tx
    import fmap_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 28,
    parameter int W          = 28
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [H*W*DATA_WIDTH-1:0] fmap,
    input  logic                      fmap_valid,
    output logic                      fmap_ready,
    fmap_stream_tx_if.master          m
);
    localparam int FW = H * W * DATA_WIDTH;
    localparam int RW = cnt_width(H);
    localparam int CW = cnt_width(W);

    state_t        state;
    logic [FW-1:0] buf_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          valid_q;
    logic          ready_q;
    logic          col_end;
    logic          row_end;

    assign col_end = (col_q == CW'(W - 1));
    assign row_end = (row_q == RW'(H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fmap_valid) begin
                        buf_q   <= fmap;
                        row_q   <= '0;
                        col_q   <= '0;
                        state   <= ST_SEND;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (m.m_ready) begin
                        buf_q <= buf_q << DATA_WIDTH;
                        if (row_end && col_end) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else if (col_end) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign fmap_ready = ready_q;
    assign m.m_valid  = valid_q;
    assign m.m_data   = buf_q[FW-1 -: DATA_WIDTH];
    assign m.m_row    = row_q;
    assign m.m_col    = col_q;
    // Gated by valid so both flags read 0 while idle.
    assign m.m_eol    = valid_q && col_end;
    assign m.m_last   = valid_q && col_end && row_end;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Scoreboard bench for fmap_stream_tx: default 28x28 instance plus a 2x3 instance.
module tb_fmap_stream_tx;
    localparam int DW = 16;
    localparam int H  = 28;
    localparam int W  = 28;
    localparam int N  = H * W;
    localparam int H2 = 2;
    localparam int W2 = 3;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  r;
        logic [7:0]  c;
        logic        eol;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [N*DW-1:0]      fmap;
    logic                 fmap_valid;
    logic                 fmap_ready;
    logic [H2*W2*DW-1:0]  fmap2;
    logic                 fmap_valid2;
    logic                 fmap_ready2;

    fmap_stream_tx_if #(.DATA_WIDTH(DW), .H(H),  .W(W))  s();
    fmap_stream_tx_if #(.DATA_WIDTH(DW), .H(H2), .W(W2)) s2();

    fmap_stream_tx #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
        .clk(clk), .rst(rst), .fmap(fmap), .fmap_valid(fmap_valid),
        .fmap_ready(fmap_ready), .m(s)
    );

    fmap_stream_tx #(.DATA_WIDTH(DW), .H(H2), .W(W2)) dut_small (
        .clk(clk), .rst(rst), .fmap(fmap2), .fmap_valid(fmap_valid2),
        .fmap_ready(fmap_ready2), .m(s2)
    );

    initial forever #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc = 0;
    int frame_beats = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int ready_mode = 0;
    bit chk_ready_next = 0;
    beat_t exp_q[$];
    beat_t exp2_q[$];
    logic [15:0] cur_map [H][W];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    always @(posedge clk) cyc++;

    // m_ready applied at posedge+2 so the main process can change mode at posedge+1
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       s.m_ready = 1'b1;
            1:       s.m_ready = 1'b0;
            default: s.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a beat is presented at the negedge before the edge that transfers it
    always @(negedge clk) begin
        beat_t act, e;
        if (!rst) begin
            if (chk_ready_next) begin
                check("ready_after_last", 64'(fmap_ready), 64'd1);
                chk_ready_next = 0;
            end
            if (s.m_valid && s.m_ready) begin
                act = {s.m_data, 8'(s.m_row), 8'(s.m_col), s.m_eol, s.m_last};
                if (act.r == 0 && act.c == 0) begin
                    frame_beats = 0;
                    first_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_beat: got %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(act), 64'(e));
                end
                frame_beats++;
                last_cyc = cyc;
                if (act.last) chk_ready_next = 1;
            end
        end
    end

    always @(negedge clk) begin
        beat_t act, e;
        if (!rst && s2.m_valid && s2.m_ready) begin
            act = {s2.m_data, 8'(s2.m_row), 8'(s2.m_col), s2.m_eol, s2.m_last};
            if (exp2_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_beat_small: got %0h expected none", act);
            end else begin
                e = exp2_q.pop_front();
                check("beat_small", 64'(act), 64'(e));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_index();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cur_map[r][c] = 16'(r * W + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cur_map[r][c] = 16'($urandom);
    endtask

    task automatic pack_fmap();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                fmap[((H - 1 - r) * W + (W - 1 - c)) * DW +: DW] = cur_map[r][c];
    endtask

    // Reference: raster order over the map, eol at the last column, last at (H-1,W-1)
    task automatic push_expect();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back({cur_map[r][c], 8'(r), 8'(c), c == W - 1,
                                 (r == H - 1) && (c == W - 1)});
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after capture.
    task automatic capture();
        int t = 0;
        while (!fmap_ready && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        if (!fmap_ready) begin
            total_cnt++;
            $display("FAIL capture_wait: got fmap_ready=0 expected 1 within 5000 cycles");
        end
        pack_fmap();
        push_expect();
        fmap_valid = 1'b1;
        @(posedge clk); #1;
        fmap_valid = 1'b0;
        check("first_beat", {s.m_valid, s.m_data, 8'(s.m_row), 8'(s.m_col)},
              {1'b1, cur_map[0][0], 8'd0, 8'd0});
    endtask

    task automatic wait_frame_beats(input int n);
        int t = 0;
        while (frame_beats != n && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        if (frame_beats != n) begin
            total_cnt++;
            $display("FAIL wait_beats: got %0d expected %0d", frame_beats, n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(fmap_ready && exp_q.size() == 0) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        if (!(fmap_ready && exp_q.size() == 0)) begin
            total_cnt++;
            $display("FAIL wait_idle: got %0d pending beats expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        fmap = '0;
        fmap_valid = 1'b0;
        fmap2 = '0;
        fmap_valid2 = 1'b0;
        s2.m_ready = 1'b1;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {fmap_ready, s.m_valid, s.m_eol, s.m_last}, 4'b1000);
        check("reset_data", {s.m_data, 8'(s.m_row), 8'(s.m_col)}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame with ready held high
        fill_index();
        cur_map[0][0] = 16'h3c00;
        cur_map[0][1] = 16'h4000;
        cur_map[H-1][W-1] = 16'hc000;
        capture();
        wait_idle();
        check("frame_span", 64'(last_cyc - first_cyc), 64'(N - 1));
        check("frame_count", 64'(frame_beats), 64'(N));
        @(posedge clk); #1;

        // Backpressure at beat 100
        fill_index();
        capture();
        wait_frame_beats(100);
        ready_mode = 1;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", {s.m_valid, s.m_data, 8'(s.m_row), 8'(s.m_col)},
                  {1'b1, 16'd100, 8'd3, 8'd16});
        end
        @(posedge clk); #1;
        ready_mode = 0;
        wait_idle();
        check("bp_count", 64'(frame_beats), 64'(N));

        // Two back-to-back random frames under random ready
        ready_mode = 2;
        fill_random();
        capture();
        fill_random();
        capture();
        wait_idle();
        ready_mode = 0;
        @(posedge clk); #1;

        // fmap_valid during SEND must be ignored
        fill_random();
        capture();
        wait_frame_beats(200);
        fill_random();
        pack_fmap();
        fmap_valid = 1'b1;
        check("busy_not_ready", 64'(fmap_ready), 64'd0);
        @(posedge clk); #1;
        fmap_valid = 1'b0;
        wait_idle();

        // Reset at beat 400 abandons the frame
        fill_random();
        capture();
        wait_frame_beats(400);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", {fmap_ready, s.m_valid, s.m_eol, s.m_last}, 4'b1000);
        check("rst_mid_data", {s.m_data, 8'(s.m_row), 8'(s.m_col)}, 32'd0);
        exp_q.delete();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        fill_random();
        capture();
        wait_idle();

        // Small 2x3 configuration
        fmap2 = 96'h0001_0002_0003_0004_0005_0006;
        for (int i = 0; i < H2 * W2; i++)
            exp2_q.push_back({16'(i + 1), 8'(i / W2), 8'(i % W2), (i % W2) == W2 - 1,
                              i == H2 * W2 - 1});
        fmap_valid2 = 1'b1;
        @(posedge clk); #1;
        fmap_valid2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("small_drained", 64'(exp2_q.size()), 64'd0);
        check("small_idle", {fmap_ready2, s2.m_valid}, 2'b10);
        check("big_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
